// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART FIFO-drain transmitter and its baud counter.
package uart_tx_fifo_drain_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
    localparam logic        UART_IDLE_LEVEL      = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts enabled cycles and flags the last cycle of each bit.
module uart_baud_cnt
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign bit_end = enable && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from a FIFO and serialises each as an 8N1-style UART frame on tx.
module uart_tx_fifo_drain
    import uart_tx_fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_ready,
    output logic                 fifo_rd,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned BIT_W = $clog2(DATA_BITS) + 1;

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 last_stop;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk    (clk),
        .rst    (rst),
        .clear  (fifo_rd),
        .enable (state_q != StIdle),
        .bit_end(bit_end)
    );

    assign last_stop = (state_q == StStop) && bit_end && (stop_cnt_q == 1'(STOP_BITS - 1));
    // The pop window is idle or the final stop cycle, so back-to-back frames have no gap.
    assign fifo_rd   = !rst && fifo_ready && ((state_q == StIdle) || last_stop);

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: ;
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                        state_d    = StStop;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            StStop: begin
                if (last_stop) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (bit_end) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (fifo_rd) begin
            shreg_d = fifo_dout;
            state_d = StStart;
        end
        // tx is registered from the next state so the line changes on the state edge.
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shreg_d[0];
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= UART_IDLE_LEVEL;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != StIdle);
    assign frame_done = done_q;

endmodule
